// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell is reused for WIDTH cycles,
// LSB first, behind a start/in_ready handshake. The result is registered and
// announced by a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Partial result; the bit that would sit at position 0 is never needed,
  // since the final update shifts in the last bit and drops nothing useful.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] acc_full;
  logic             last_bit;

  full_adder u_fa (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign acc_full = {fa_sum, acc_q};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath update; everything holds unless the state acts.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        acc_d   = acc_full[WIDTH-1:1];
        carry_d = fa_cout;
        // Clear rather than step past WIDTH-1 on the final bit.
        cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = acc_full;
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset clears everything including the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;

endmodule

// One-bit full adder cell shared by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed tests at WIDTH=8, exhaustive at WIDTH=2,
// random traffic at WIDTH=16, with a queue-based scoreboard per instance.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [32:0] val;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q16[$];

  // WIDTH=8 instance
  logic        rst8, start8, cin8, in_ready8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  // WIDTH=2 and WIDTH=16 instances share a reset
  logic        rst;
  logic        start2, cin2, in_ready2, busy2, done2, cout2;
  logic [1:0]  a2, b2, sum2;
  logic        start16, cin16, in_ready16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int acc8 = 0, acc2 = 0, acc16 = 0;
  int done8_n = 0, done2_n = 0, done16_n = 0;
  int done8_last = 0, done8_prev = 0;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .in_ready(in_ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .in_ready(in_ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .in_ready(in_ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Acceptance monitors: push the expected sum when a handshake completes.
  always @(posedge clk) begin
    if (rst8) q8.delete();
    else if (start8 && in_ready8) begin
      q8.push_back('{33'(a8) + 33'(b8) + 33'(cin8), cyc});
      acc8 <= acc8 + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) q2.delete();
    else if (start2 && in_ready2) begin
      q2.push_back('{33'(a2) + 33'(b2) + 33'(cin2), cyc});
      acc2 <= acc2 + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) q16.delete();
    else if (start16 && in_ready16) begin
      q16.push_back('{33'(a16) + 33'(b16) + 33'(cin16), cyc});
      acc16 <= acc16 + 1;
    end
  end

  // Completion monitors: pop and compare value and latency on each done.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      done8_prev = done8_last;
      done8_last = cyc;
      done8_n++;
      check_eq("u8_pending", 64'(q8.size() != 0), 64'(1));
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check_eq("u8_result", 64'({cout8, sum8}), 64'(e.val));
        check_eq("u8_latency", 64'(cyc - e.cyc), 64'(9));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      done2_n++;
      check_eq("u2_pending", 64'(q2.size() != 0), 64'(1));
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check_eq("u2_result", 64'({cout2, sum2}), 64'(e.val));
        check_eq("u2_latency", 64'(cyc - e.cyc), 64'(3));
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      done16_n++;
      check_eq("u16_pending", 64'(q16.size() != 0), 64'(1));
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check_eq("u16_result", 64'({cout16, sum16}), 64'(e.val));
        check_eq("u16_latency", 64'(cyc - e.cyc), 64'(17));
      end
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int old = acc8;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    for (int n = 0; n < 40 && acc8 == old; n++) begin
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    check_eq("u8_accept", 64'(acc8 != old), 64'(1));
  endtask

  task automatic wait_acc8(input int target);
    for (int n = 0; n < 40 && acc8 < target; n++) begin
      @(posedge clk); #1;
    end
    check_eq("u8_acc_wait", 64'(acc8 >= target), 64'(1));
  endtask

  task automatic wait_done8(input int target);
    for (int n = 0; n < 40 && done8_n < target; n++) begin
      @(posedge clk); #1;
    end
    check_eq("u8_done_wait", 64'(done8_n >= target), 64'(1));
  endtask

  task automatic go2(input logic [1:0] a, input logic [1:0] b, input logic c);
    int old = acc2;
    a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
    for (int n = 0; n < 20 && acc2 == old; n++) begin
      @(posedge clk); #1;
    end
    start2 = 1'b0;
    check_eq("u2_accept", 64'(acc2 != old), 64'(1));
  endtask

  initial begin : main
    int old;
    int d0;
    int n;
    logic [4:0] v;

    rst8 = 1'b1; rst = 1'b1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;  // reset must win over start
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0; rst = 1'b0; start8 = 1'b0;

    // Reset state
    check_eq("rst_in_ready", 64'(in_ready8), 64'(1));
    check_eq("rst_busy", 64'(busy8), 64'(0));
    check_eq("rst_done", 64'(done8), 64'(0));
    check_eq("rst_sum", 64'(sum8), 64'(0));
    check_eq("rst_cout", 64'(cout8), 64'(0));
    check_eq("rst_in_ready16", 64'(in_ready16), 64'(1));

    // 0x5A + 0x3C: busy for 9 cycles, done on the last, result held until then
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check_eq("t1_in_ready_drop", 64'(in_ready8), 64'(0));
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check_eq("t1_busy", 64'(busy8), 64'(1));
      check_eq("t1_done", 64'(done8), 64'(k == 8));
      check_eq("t1_sum", 64'(sum8), (k == 8) ? 64'h96 : 64'h0);
    end
    @(negedge clk);
    check_eq("t1_idle_busy", 64'(busy8), 64'(0));
    check_eq("t1_idle_ready", 64'(in_ready8), 64'(1));
    check_eq("t1_cout", 64'(cout8), 64'(0));

    // Back-to-back with start held high
    @(posedge clk); #1;
    old = acc8; d0 = done8_n;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    wait_acc8(old + 1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    wait_acc8(old + 2);
    start8 = 1'b0;
    wait_done8(d0 + 2);
    check_eq("t2_done_spacing", 64'(done8_last - done8_prev), 64'(10));
    check_eq("t2_sum", 64'(sum8), 64'hFF);
    check_eq("t2_cout", 64'(cout8), 64'(1));

    // start during RUN is ignored; result holds until DONE
    old = acc8; d0 = done8_n;
    go8(8'h01, 8'h01, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t3_sum_hold", 64'(sum8), 64'hFF);
    check_eq("t3_no_accept", 64'(acc8), 64'(old + 1));
    start8 = 1'b0;
    wait_done8(d0 + 1);
    check_eq("t3_sum", 64'(sum8), 64'h02);
    check_eq("t3_accepts", 64'(acc8), 64'(old + 1));

    // Reset in the middle of RUN aborts without a done pulse
    go8(8'h33, 8'h44, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    check_eq("t4_in_ready", 64'(in_ready8), 64'(1));
    check_eq("t4_busy", 64'(busy8), 64'(0));
    check_eq("t4_sum", 64'(sum8), 64'(0));
    check_eq("t4_cout", 64'(cout8), 64'(0));
    d0 = done8_n;
    repeat (12) begin @(posedge clk); #1; end
    check_eq("t4_no_done", 64'(done8_n), 64'(d0));
    go8(8'hC8, 8'h5A, 1'b1);
    wait_done8(d0 + 1);
    check_eq("t4_fresh_sum", 64'(sum8), 64'h23);
    check_eq("t4_fresh_cout", 64'(cout8), 64'(1));

    // WIDTH=2 exhaustive
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      go2(v[1:0], v[3:2], v[4]);
    end
    for (n = 0; n < 20 && done2_n < 32; n++) begin
      @(posedge clk); #1;
    end
    check_eq("u2_done_count", 64'(done2_n), 64'(32));

    // WIDTH=16 random traffic, operands and start toggling every cycle
    for (n = 0; n < 60000 && acc16 < 1000; n++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      start16 = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    start16 = 1'b0;
    check_eq("u16_accepts", 64'(acc16), 64'(1000));
    for (n = 0; n < 40 && done16_n < acc16; n++) begin
      @(posedge clk); #1;
    end
    check_eq("u16_done_count", 64'(done16_n), 64'(acc16));
    check_eq("u16_queue_empty", 64'(q16.size()), 64'(0));
    check_eq("u8_queue_empty", 64'(q8.size()), 64'(0));
    check_eq("u2_queue_empty", 64'(q2.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller. It time-multiplexes one 1-bit full-adder cell (the existing full_adder module, instantiated once inside) across a WIDTH-bit operand pair, LSB first.
- Sequences shift registers, a carry flop and a bit counter.
- Accepts operands via a start/in_ready handshake.
- Presents a registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits between a requester (e.g. register-file or test-harness logic) and the full-adder datapath, trading area for latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      request; accepted only when in_ready=1
- a      input   WIDTH  operand A, sampled on acceptance
- b      input   WIDTH  operand B, sampled on acceptance
- cin    input   1      carry-in, sampled on acceptance
- in_ready  output  1   high only in IDLE
- busy   output  1      high in RUN and DONE
- done   output  1      one-cycle pulse, high in DONE
- sum    output  WIDTH  registered result
- cout   output  1      registered final carry

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - sum=0, cout=0, done=0, busy=0, in_ready=1 in the following cycle.
  - Shift registers, carry flop and counter are cleared.
  - rst overrides start in the same cycle.
  - Reset during RUN or DONE aborts the operation. No done pulse, and sum/cout are zeroed, not partially updated.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - If start=1 at the edge: sa<=a, sb<=b, carry<=cin, cnt<=0, acc<=0, next state RUN.
  - Otherwise stay in IDLE.
- RUN, every cycle:
  - The full-adder cell is fed sa[0], sb[0], carry.
  - acc <= {fa_sum, acc[WIDTH-1:1]} (result shifts in at the MSB).
  - sa, sb shift right by 1 with zero fill.
  - carry <= fa_cout; cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge, the update is the final bit:
    - next state DONE;
    - sum <= {fa_sum, acc[WIDTH-1:1]} (the full result);
    - cout <= fa_cout.
- DONE:
  - done=1 for exactly one cycle.
  - Next state IDLE unconditionally.
- Latency: start accepted at edge E0. RUN spans WIDTH cycles. done is high in the cycle after edge E0+WIDTH. Result is visible from that cycle. Throughput is one op per WIDTH+2 cycles.
- sum/cout hold the previous result through IDLE and RUN. They change only on entry to DONE or on reset.
- start while busy=1 is ignored and not queued. The requester must hold start until it sees in_ready=1.
- Operand inputs a/b/cin may change freely after acceptance. Only the latched copies are used.
- Arithmetic is modulo 2^WIDTH on sum; the overflow carry goes to cout. Result equals {cout,sum} = a+b+cin.
- Counter never exceeds WIDTH-1. No wrap occurs inside RUN.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed at E0 → in_ready drops, busy=1 for 9 cycles, done high in cycle after E0+8, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Back-to-back start held high → second accepted in first IDLE cycle after DONE; done pulses exactly 10 cycles apart.
- start asserted with a=0x11, b=0x22 during RUN of an op (a=0x01, b=0x01) → ignored; result 0x02. sum stays at the prior value until DONE.
- rst asserted at cycle 4 of RUN → next cycle state IDLE, sum=0, cout=0, no done pulse. A fresh op then gives a correct result.
- WIDTH=2 build, exhaustive over all a, b, cin (32 cases) → {cout,sum} == a+b+cin, done 3 cycles after each acceptance edge.
- Random 1000 ops at WIDTH=16, with random start gaps and random operand changes while busy → scoreboard match, done count == accepted count.
